frame_writer: RTL

- Sits directly downstream of the pixel renderer.
- Consumes its 24-bit pixel AXI-Stream plus the delayed hcount/vcount sideband.
- Converts each pixel to RGB565 and writes it into a double-buffered BRAM frame buffer at address row*H_RES+col.
- Flags frame completion and swaps buffers so the display side reads a finished frame while the next frame renders.

---
 rtl/frame_writer_if.sv | 39 +++
 rtl/frame_writer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/frame_writer_if.sv
// Pixel stream plus frame-buffer write port of the frame writer.
// The slave modport is the frame_writer side. The master modport is the renderer/memory side.
interface frame_writer_if #(
    parameter int unsigned ADDR_W = 17
);
    logic [23:0]       pixel_axis_tdata;
    logic              pixel_axis_tvalid;
    logic              pixel_axis_tready;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic [ADDR_W-1:0] fb_addr;
    logic [15:0]       fb_data;
    logic              fb_we;
    logic              fb_ready;

    modport slave (
        input  pixel_axis_tdata,
        input  pixel_axis_tvalid,
        output pixel_axis_tready,
        input  hcount_in,
        input  vcount_in,
        output fb_addr,
        output fb_data,
        output fb_we,
        input  fb_ready
    );

    modport master (
        output pixel_axis_tdata,
        output pixel_axis_tvalid,
        input  pixel_axis_tready,
        output hcount_in,
        output vcount_in,
        input  fb_addr,
        input  fb_data,
        input  fb_we,
        output fb_ready
    );
endinterface

// File: rtl/frame_writer.sv
// Writes RGB565-converted renderer pixels into a double-buffered frame buffer.
// Swaps buffers at the end of each frame.
module frame_writer #(
    parameter int unsigned H_RES  = 320,
    parameter int unsigned V_RES  = 180,
    parameter int unsigned ADDR_W = 17
) (
    input  logic                aclk,
    input  logic                aresetn,
    frame_writer_if.slave       pix,
    input  logic                swap_enable,
    output logic                write_buf,
    output logic                display_buf,
    output logic                frame_done,
    output logic [15:0]         frame_count,
    output logic [15:0]         drop_count
);
    localparam int unsigned FRAME_PIX = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(FRAME_PIX);

    logic              s1_valid_q, s1_in_range_q, s1_last_q;
    logic [15:0]       s1_data_q;
    logic [10:0]       s1_hcount_q;
    logic [ADDR_W-1:0] s1_row_base_q;

    logic              s2_valid_q, s2_in_range_q, s2_last_q;
    logic [15:0]       s2_data_q;
    logic [ADDR_W-1:0] s2_offset_q;

    logic              write_buf_q, write_buf_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [15:0]       drop_count_q, drop_count_d;

    logic              adv1_c, adv2_c, accept_c, frame_end_c;
    logic [15:0]       rgb565_c;
    logic              in_range_c, last_c;
    logic [ADDR_W-1:0] row_base_c;
    logic              unused_c;

    // Stage advance: S2 only waits on memory when it holds a real write.
    always_comb begin
        adv2_c   = !s2_valid_q || !s2_in_range_q || pix.fb_ready;
        adv1_c   = !s1_valid_q || adv2_c;
        accept_c = pix.pixel_axis_tvalid && adv1_c;
    end

    assign pix.pixel_axis_tready = adv1_c && aresetn;

    always_comb begin
        rgb565_c   = {pix.pixel_axis_tdata[23:19], pix.pixel_axis_tdata[15:10],
                      pix.pixel_axis_tdata[7:3]};
        in_range_c = (pix.hcount_in < 11'(H_RES)) && (pix.vcount_in < 10'(V_RES));
        last_c     = (pix.hcount_in == 11'(H_RES - 1)) && (pix.vcount_in == 10'(V_RES - 1));
        row_base_c = ADDR_W'(pix.vcount_in) * ADDR_W'(H_RES);
    end

    // Truncated colour LSBs are intentionally dropped.
    assign unused_c = ^{pix.pixel_axis_tdata[18:16], pix.pixel_axis_tdata[9:8],
                        pix.pixel_axis_tdata[2:0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_q    <= 1'b0;
            s1_in_range_q <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_data_q     <= '0;
            s1_hcount_q   <= '0;
            s1_row_base_q <= '0;
        end else if (adv1_c) begin
            s1_valid_q    <= accept_c;
            s1_in_range_q <= in_range_c;
            s1_last_q     <= last_c;
            s1_data_q     <= rgb565_c;
            s1_hcount_q   <= pix.hcount_in;
            s1_row_base_q <= row_base_c;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s2_valid_q    <= 1'b0;
            s2_in_range_q <= 1'b0;
            s2_last_q     <= 1'b0;
            s2_data_q     <= '0;
            s2_offset_q   <= '0;
        end else if (adv2_c) begin
            s2_valid_q    <= s1_valid_q;
            s2_in_range_q <= s1_in_range_q;
            s2_last_q     <= s1_last_q;
            s2_data_q     <= s1_data_q;
            s2_offset_q   <= s1_row_base_q + ADDR_W'(s1_hcount_q);
        end
    end

    assign pix.fb_we   = s2_valid_q && s2_in_range_q;
    assign pix.fb_data = s2_data_q;
    assign pix.fb_addr = s2_offset_q + (write_buf_q ? BUF1_BASE : '0);

    // Frame bookkeeping; the last-pixel write itself still targets the old buffer.
    always_comb begin
        frame_end_c   = pix.fb_we && pix.fb_ready && s2_last_q;
        write_buf_d   = write_buf_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        frame_done_d  = frame_end_c;
        if (frame_end_c) begin
            frame_count_d = frame_count_q + 16'd1;
            if (swap_enable) begin
                write_buf_d = !write_buf_q;
            end
        end
        if (s2_valid_q && !s2_in_range_q && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            write_buf_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            write_buf_q   <= write_buf_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign write_buf   = write_buf_q;
    assign display_buf = !write_buf_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
endmodule
